// File: rtl/pdh_capture_sequencer_if.sv
// Stream bundle carrying captured PDH words from the capture sequencer to the DMA engine.
// valid/ready: a word transfers on a cycle where tvalid & tready are both high; once tvalid rises,
// tdata/tlast stay stable and tvalid stays high until that transfer (or an abort) happens.
interface pdh_capture_sequencer_if #(
  parameter int DATA_WIDTH = 64
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/pdh_capture_sequencer.sv
// Sequences one DMA frame capture of the PDH datapath word onto a valid/ready stream.
// Optional watchdog on the DMA wait states is built only when PDH_SEQ_TIMEOUT_EN is defined.
module pdh_capture_sequencer #(
  parameter int DATA_WIDTH     = 64,
  parameter int LEN_WIDTH      = 16,
  parameter int DECIM_WIDTH    = 8,
  parameter int TIMEOUT_CYCLES = 2**24
) (
  input  logic                   clk,
  input  logic                   rst_ni,
  input  logic                   arm_i,
  input  logic                   abort_i,
  input  logic [LEN_WIDTH-1:0]   frame_len_i,
  input  logic [DECIM_WIDTH-1:0] decim_i,
  input  logic [DATA_WIDTH-1:0]  sample_i,
  input  logic                   dma_engaged_i,
  input  logic                   dma_finished_i,
  pdh_capture_sequencer_if.master m,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   overflow_o,
  output logic                   timeout_o,
  output logic [2:0]             state_o,
  output logic [LEN_WIDTH-1:0]   count_o
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_ENG = 3'd1,
    S_CAPTURE  = 3'd2,
    S_WAIT_FIN = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [LEN_WIDTH-1:0]   len_q, count_q, loaded_q;
  logic [DECIM_WIDTH-1:0] decim_q, decim_cnt_q;
  logic [DATA_WIDTH-1:0]  tdata_q;
  logic                   tvalid_q, overflow_q;
  logic                   arm_ok, tick, room, reg_free, hs, last_word, wd_expire;

  assign arm_ok    = (state_q == S_IDLE) && arm_i && !abort_i && (frame_len_i != '0);
  assign tick      = (state_q == S_CAPTURE) && (decim_cnt_q == decim_q);
  assign room      = (loaded_q != len_q);
  assign reg_free  = !tvalid_q || m.tready;
  assign hs        = tvalid_q && m.tready;
  assign last_word = (count_q == len_q - LEN_WIDTH'(1));

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (abort_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:     if (arm_ok) state_d = S_WAIT_ENG;
        S_WAIT_ENG: if (dma_engaged_i) state_d = S_CAPTURE;
                    else if (wd_expire) state_d = S_IDLE;
        S_CAPTURE:  if (hs && last_word) state_d = S_WAIT_FIN;
        S_WAIT_FIN: if (dma_finished_i) state_d = S_DONE;
                    else if (wd_expire) state_d = S_IDLE;
        S_DONE:     state_d = S_IDLE;
        default:    state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy_o     = (state_q != S_IDLE);
    done_o     = (state_q == S_DONE);
    state_o    = state_q;
    count_o    = count_q;
    overflow_o = overflow_q;
  end

  assign m.tdata  = tdata_q;
  assign m.tvalid = tvalid_q;
  assign m.tlast  = tvalid_q && last_word;

  // A tick that finds the output register still stalled drops its sample rather than queueing it.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      len_q       <= '0;
      decim_q     <= '0;
      count_q     <= '0;
      loaded_q    <= '0;
      decim_cnt_q <= '0;
      tdata_q     <= '0;
      tvalid_q    <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      if (arm_ok) begin
        len_q      <= frame_len_i;
        decim_q    <= decim_i;
        count_q    <= '0;
        loaded_q   <= '0;
        overflow_q <= 1'b0;
      end
      if (abort_i) begin
        tvalid_q    <= 1'b0;
        decim_cnt_q <= '0;
      end else if (state_q == S_CAPTURE) begin
        decim_cnt_q <= tick ? '0 : decim_cnt_q + DECIM_WIDTH'(1);
        if (hs) count_q <= count_q + LEN_WIDTH'(1);
        if (tick && room && reg_free) begin
          tdata_q  <= sample_i;
          tvalid_q <= 1'b1;
          loaded_q <= loaded_q + LEN_WIDTH'(1);
        end else if (hs) begin
          tvalid_q <= 1'b0;
        end
        if (tick && room && !reg_free) overflow_q <= 1'b1;
      end else begin
        decim_cnt_q <= '0;
      end
    end
  end

`ifdef PDH_SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_q;
  logic            timeout_q, wait_st;

  assign wait_st   = (state_q == S_WAIT_ENG) || (state_q == S_WAIT_FIN);
  assign wd_expire = wait_st && (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
  assign timeout_o = timeout_q;

  // Leaving a wait state to IDLE without abort can only be the watchdog firing.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_q <= (!wait_st || state_d != state_q) ? '0 : wd_q + WD_W'(1);
      if (arm_ok) timeout_q <= 1'b0;
      else if (wait_st && !abort_i && state_d == S_IDLE) timeout_q <= 1'b1;
    end
  end
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign wd_expire = 1'b0;
  assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_pdh_capture_sequencer.sv
// Randomized frame captures checked against a cycle-level model of the capture rules via a stream scoreboard.
module tb_pdh_capture_sequencer;
  localparam int DW = 64;
  localparam int LW = 16;
  localparam int DCW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          arm = 1'b0, abort = 1'b0, engaged = 1'b0, finished = 1'b0;
  logic [LW-1:0] frame_len = '0;
  logic [DCW-1:0] decim = '0;
  logic [DW-1:0] sample = '0;
  logic          busy, done, overflow, timeout;
  logic [2:0]    state;
  logic [LW-1:0] count;

  logic [DW:0]   exp_q[$];
  int            n_checks = 0;
  int            n_fail = 0;

  pdh_capture_sequencer_if #(.DATA_WIDTH(DW)) m_if ();

  pdh_capture_sequencer #(
    .DATA_WIDTH(DW), .LEN_WIDTH(LW), .DECIM_WIDTH(DCW), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst_ni(rst_n), .arm_i(arm), .abort_i(abort),
    .frame_len_i(frame_len), .decim_i(decim), .sample_i(sample),
    .dma_engaged_i(engaged), .dma_finished_i(finished), .m(m_if),
    .busy_o(busy), .done_o(done), .overflow_o(overflow), .timeout_o(timeout),
    .state_o(state), .count_o(count)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL sim_time_limit: simulation did not finish in time");
    $fatal(1, "time limit");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // monitor: pops the scoreboard on every transfer, checks stall stability
  logic          prev_stall = 1'b0;
  logic          prev_abort = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic [DW:0]   exp_w;

  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_stall && !prev_abort) begin
        check("hold_valid", m_if.tvalid, 1);
        check("hold_data", m_if.tdata, prev_data);
      end
      if (m_if.tvalid && m_if.tready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL stream_extra_word: got %0h expected none", m_if.tdata);
        end else begin
          exp_w = exp_q.pop_front();
          check("tdata", m_if.tdata, exp_w[DW-1:0]);
          check("tlast", {63'd0, m_if.tlast}, {63'd0, exp_w[DW]});
        end
      end
      prev_stall = m_if.tvalid && !m_if.tready;
      prev_data  = m_if.tdata;
      prev_abort = abort;
    end
  end

  // driver + reference model: each capture cycle k ticks when k mod (decim+1) == decim;
  // a tick loads the sample if the stream slot is empty or transferring, else it is dropped.
  task automatic run_frame(input int len, input int dec, input int mode, input int eng_delay,
                           input int fin_delay, input int abort_after, input bit arm_mid);
    int  k = 0, loaded = 0, delivered = 0;
    bit  occ = 0, exp_ovf = 0, hs, tk, rdy;
    frame_len = LW'(len);
    decim = DCW'(dec);
    arm = 1'b1;
    step();
    arm = 1'b0;
    check("arm_state", state, 1);
    check("arm_ovf_clear", overflow, 0);
    check("arm_count_clear", count, 0);
    check("arm_timeout_clear", timeout, 0);
    repeat (eng_delay) step();
    engaged = 1'b1;
    step();
    engaged = 1'b0;
    check("capture_state", state, 2);
    while (delivered < len && k < 5000) begin
      sample = {$urandom, $urandom};
      case (mode)
        0: rdy = 1'b1;
        1: rdy = ($urandom_range(0, 3) != 0);
        default: rdy = !(k >= 3 && k <= 6);
      endcase
      m_if.tready = rdy;
      if (arm_mid && k == 1) begin
        arm = 1'b1;
        frame_len = LW'(len + 5);
      end
      if (abort_after > 0 && delivered == abort_after) begin
        m_if.tready = 1'b0;
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_tvalid", m_if.tvalid, 0);
        check("abort_state", state, 0);
        exp_q.delete();
        repeat (3) begin
          check("abort_no_done", done, 0);
          step();
        end
        return;
      end
      hs = occ && rdy;
      tk = ((k % (dec + 1)) == dec);
      if (hs) delivered++;
      if (tk && loaded < len && (!occ || rdy)) begin
        exp_q.push_back({(loaded + 1 == len), sample});
        loaded++;
        occ = 1'b1;
      end else begin
        if (tk && loaded < len) exp_ovf = 1'b1;
        occ = occ && !rdy;
      end
      step();
      arm = 1'b0;
      k++;
    end
    check("capture_words", delivered, len);
    m_if.tready = 1'b1;
    check("wait_fin_state", state, 3);
    check("wait_fin_tvalid", m_if.tvalid, 0);
    check("overflow", overflow, exp_ovf);
    check("count_final", count, len);
    repeat (fin_delay) begin
      check("no_early_done", done, 0);
      step();
    end
    finished = 1'b1;
    step();
    finished = 1'b0;
    check("done_pulse", done, 1);
    check("done_state", state, 4);
    step();
    check("done_one_cycle", done, 0);
    check("idle_state", state, 0);
    check("idle_busy", busy, 0);
    check("count_hold", count, len);
    check("scoreboard_empty", exp_q.size(), 0);
  endtask

  initial begin
    m_if.tready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", state, 0);
    check("rst_tvalid", m_if.tvalid, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_count", count, 0);
    check("rst_overflow", overflow, 0);
    check("rst_timeout", timeout, 0);
    step();
    rst_n = 1'b1;
    step();

    run_frame(4, 0, 0, 3, 5, 0, 0);
    run_frame(3, 2, 0, 1, 1, 0, 0);
    run_frame(8, 0, 2, 0, 2, 0, 0);
    run_frame(6, 0, 0, 1, 0, 2, 0);
    run_frame(2, 0, 0, 0, 1, 0, 0);

    // arm + abort together, zero-length arm
    frame_len = 5;
    arm = 1'b1;
    abort = 1'b1;
    step();
    arm = 1'b0;
    abort = 1'b0;
    check("arm_abort_idle", state, 0);
    frame_len = 0;
    arm = 1'b1;
    step();
    arm = 1'b0;
    check("arm_len0_idle", state, 0);
    check("arm_len0_busy", busy, 0);
    run_frame(4, 1, 0, 0, 0, 0, 1);

    for (int i = 0; i < 8; i++)
      run_frame($urandom_range(1, 10), $urandom_range(0, 3), 1,
                $urandom_range(0, 3), $urandom_range(0, 3), 0, 0);

    // watchdog on a DMA engine that never engages
    frame_len = 3;
    arm = 1'b1;
    step();
    arm = 1'b0;
    repeat (15) step();
    check("wd_before_limit", state, 1);
    step();
`ifdef PDH_SEQ_TIMEOUT_EN
    check("wd_state", state, 0);
    check("wd_timeout", timeout, 1);
    arm = 1'b1;
    step();
    arm = 1'b0;
    check("wd_cleared_by_arm", timeout, 0);
`else
    check("no_wd_state", state, 1);
    check("no_wd_timeout", timeout, 0);
`endif
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("wd_abort_idle", state, 0);

    // asynchronous reset mid-operation
    frame_len = 3;
    arm = 1'b1;
    step();
    arm = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_state", state, 0);
    check("midrst_busy", busy, 0);
    step();
    rst_n = 1'b1;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
